// File: rtl/useq_fifo_bridge.sv
// rtl/useq_fifo_bridge.sv - useq FIFO port bridge: two-requester burst-locked round-robin writer plus registered drain stream
module useq_fifo_bridge #(
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  wr_valid,
    input  logic [7:0]  wr_data0,
    input  logic [7:0]  wr_data1,
    output logic [1:0]  wr_ready,
    output logic        write_fifo,
    output logic [7:0]  fifo_in,
    input  logic        fifo_full,
    output logic        read_fifo,
    input  logic [7:0]  fifo_out,
    input  logic        fifo_empty,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    input  logic        rd_ready,
    output logic [15:0] wr_count
);

    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    logic       last;
    logic       lock;
    logic       own;
    logic [3:0] bcnt;
    logic [3:0] bcnt_nxt;
    logic       sel;
    logic       push;
    logic       pop;

    // Grant, push and pop strobes are all masked while rst is high.
    always_comb begin
        if (lock)
            sel = own;
        else if (&wr_valid)
            sel = ~last;
        else
            sel = wr_valid[1];

        wr_ready = 2'b00;
        if (!rst && (|wr_valid) && !fifo_full)
            wr_ready[sel] = 1'b1;

        push     = wr_valid[sel] & wr_ready[sel];
        fifo_in  = sel ? wr_data1 : wr_data0;
        bcnt_nxt = lock ? bcnt + 4'd1 : 4'd1;
        pop      = !rst && !fifo_empty && (!rd_valid || rd_ready);
    end

    assign write_fifo = push;
    assign read_fifo  = pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last     <= 1'b1;
            lock     <= 1'b0;
            own      <= 1'b0;
            bcnt     <= 4'd0;
            wr_count <= 16'd0;
            rd_valid <= 1'b0;
            rd_data  <= 8'h00;
        end else begin
            if (push) begin
                last     <= sel;
                own      <= sel;
                wr_count <= wr_count + 16'd1;
                bcnt     <= bcnt_nxt;
                lock     <= (bcnt_nxt < MAX_B);
            end else if (lock && !wr_valid[own]) begin
                // Owner walked away; a full FIFO alone keeps the lock.
                lock <= 1'b0;
                bcnt <= 4'd0;
            end

            if (pop) begin
                rd_data  <= fifo_out;
                rd_valid <= 1'b1;
            end else if (rd_ready) begin
                rd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_useq_fifo_bridge.sv
// tb/tb_useq_fifo_bridge.sv - scoreboard bench for useq_fifo_bridge
`timescale 1ns/1ps
module tb_useq_fifo_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  wv4, wv1;
    logic [7:0]  wr_data0, wr_data1;
    logic        fifo_full, rd_ready, hold_ne, mon_en;
    logic [7:0]  fifo_out;
    logic        fifo_empty;

    logic [1:0]  wr_ready, wr_ready1;
    logic        write_fifo, write_fifo1, read_fifo, read_fifo1;
    logic [7:0]  fifo_in, fifo_in1, rd_data, rd_data1;
    logic        rd_valid, rd_valid1;
    logic [15:0] wr_count, wr_count1;

    logic [7:0]  mem [0:7];
    int          rptr = 0;
    int          wptr = 0;

    logic [7:0]  exp4[$];
    logic [7:0]  exp1[$];
    logic [7:0]  exp_rd[$];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign wr_data0   = 8'hA0;
    assign wr_data1   = 8'hB1;
    assign fifo_out   = mem[rptr[2:0]];
    assign fifo_empty = (rptr == wptr) && !hold_ne;

    always @(posedge clk) if (read_fifo) rptr <= rptr + 1;

    useq_fifo_bridge #(.MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .wr_valid(wv4), .wr_data0(wr_data0), .wr_data1(wr_data1),
        .wr_ready(wr_ready), .write_fifo(write_fifo), .fifo_in(fifo_in), .fifo_full(fifo_full),
        .read_fifo(read_fifo), .fifo_out(fifo_out), .fifo_empty(fifo_empty),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready), .wr_count(wr_count)
    );

    useq_fifo_bridge #(.MAX_BURST(1)) dut1 (
        .clk(clk), .rst(rst), .wr_valid(wv1), .wr_data0(wr_data0), .wr_data1(wr_data1),
        .wr_ready(wr_ready1), .write_fifo(write_fifo1), .fifo_in(fifo_in1), .fifo_full(fifo_full),
        .read_fifo(read_fifo1), .fifo_out(fifo_out), .fifo_empty(fifo_empty),
        .rd_valid(rd_valid1), .rd_data(rd_data1), .rd_ready(rd_ready), .wr_count(wr_count1)
    );

    function automatic logic [7:0] src(input int r);
        return (r != 0) ? 8'hB1 : 8'hA0;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [7:0] e;
        if (mon_en && write_fifo) begin
            n_vec++;
            if (exp4.size() == 0) begin
                n_err++;
                $display("FAIL push4_unexpected: got fifo_in %h, expected no push", fifo_in);
            end else begin
                e = exp4.pop_front();
                if (fifo_in !== e) begin
                    n_err++;
                    $display("FAIL push4: got fifo_in %h, expected %h", fifo_in, e);
                end
            end
        end
        if (mon_en && write_fifo1) begin
            n_vec++;
            if (exp1.size() == 0) begin
                n_err++;
                $display("FAIL push1_unexpected: got fifo_in %h, expected no push", fifo_in1);
            end else begin
                e = exp1.pop_front();
                if (fifo_in1 !== e) begin
                    n_err++;
                    $display("FAIL push1: got fifo_in %h, expected %h", fifo_in1, e);
                end
            end
        end
        if (rd_valid && rd_ready) begin
            n_vec++;
            if (exp_rd.size() == 0) begin
                n_err++;
                $display("FAIL drain_unexpected: got rd_data %h, expected no output", rd_data);
            end else begin
                e = exp_rd.pop_front();
                if (rd_data !== e) begin
                    n_err++;
                    $display("FAIL drain: got rd_data %h, expected %h", rd_data, e);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [3:0] ord4 [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
        logic [3:0] rr1  [6]  = '{0, 1, 0, 1, 1, 1};
        logic [3:0] bp4  [6]  = '{1, 1, 1, 1, 0, 0};

        rst = 1'b1; wv4 = 2'b11; wv1 = 2'b11; hold_ne = 1'b1;
        fifo_full = 1'b0; rd_ready = 1'b0; mon_en = 1'b1;
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;

        // Reset values with requesters and the outbound FIFO active
        @(negedge clk);
        chk("rst_write_fifo", 16'(write_fifo), 16'd0);
        chk("rst_write_fifo1", 16'(write_fifo1), 16'd0);
        chk("rst_read_fifo", 16'(read_fifo), 16'd0);
        chk("rst_wr_ready", 16'(wr_ready), 16'd0);
        chk("rst_rd_valid", 16'(rd_valid), 16'd0);
        chk("rst_wr_count", wr_count, 16'd0);
        wv4 = 2'b00; wv1 = 2'b00; hold_ne = 1'b0;
        @(posedge clk); #1 rst = 1'b0;

        // Burst lock vs pure round-robin, both requesters valid for 10 cycles
        for (int i = 0; i < 10; i++) begin
            exp4.push_back(src(int'(ord4[i])));
            exp1.push_back(src(i % 2));
        end
        wv4 = 2'b11; wv1 = 2'b11;
        repeat (10) @(posedge clk);
        #1 wv4 = 2'b00; wv1 = 2'b00;
        @(negedge clk);
        chk("burst_wr_count", wr_count, 16'd10);
        chk("rr_wr_count", wr_count1, 16'd10);

        // Round-robin with requester 0 dropping out
        for (int i = 0; i < 6; i++) exp1.push_back(src(int'(rr1[i])));
        @(posedge clk); #1 wv1 = 2'b11;
        repeat (3) @(posedge clk);
        #1 wv1 = 2'b10;
        repeat (3) @(posedge clk);
        #1 wv1 = 2'b00;

        // Full back-pressure in the middle of a requester-1 burst
        for (int i = 0; i < 6; i++) exp4.push_back(src(int'(bp4[i])));
        wv4 = 2'b10;
        @(posedge clk); #1 wv4 = 2'b11;
        @(posedge clk); #1 fifo_full = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("full_write_fifo", 16'(write_fifo), 16'd0);
            chk("full_wr_ready", 16'(wr_ready), 16'd0);
        end
        @(posedge clk); #1 fifo_full = 1'b0;
        repeat (4) @(posedge clk);
        #1 wv4 = 2'b00;
        @(negedge clk);
        chk("bp_wr_count", wr_count, 16'd16);

        // Drain stream A1,B2,C3 with rd_ready high
        exp_rd.push_back(8'hA1); exp_rd.push_back(8'hB2); exp_rd.push_back(8'hC3);
        @(posedge clk); #1;
        rd_ready = 1'b1;
        mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3; wptr = 3;
        @(negedge clk);
        chk("drain_first_pop", 16'(read_fifo), 16'd1);
        chk("drain_latency_rd_valid0", 16'(rd_valid), 16'd0);
        @(negedge clk);
        chk("drain_latency_rd_valid1", 16'(rd_valid), 16'd1);
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rptr == wptr && !rd_valid) break;
        end
        chk("drain_done", 16'(k < 20), 16'd1);

        // Consumer stall holds rd_data and blocks pops
        exp_rd.push_back(8'hD4); exp_rd.push_back(8'hE5);
        @(posedge clk); #1;
        rd_ready = 1'b0;
        mem[3] = 8'hD4; mem[4] = 8'hE5; wptr = 5;
        @(posedge clk);
        repeat (2) begin
            @(negedge clk);
            chk("hold_rd_valid", 16'(rd_valid), 16'd1);
            chk("hold_rd_data", 16'(rd_data), 16'h00D4);
            chk("hold_read_fifo", 16'(read_fifo), 16'd0);
        end
        @(posedge clk); #1 rd_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Counter preload to 0xFFFE, then wrap
        mon_en = 1'b0;
        wv4 = 2'b01;
        repeat (65518) @(posedge clk);
        #1 wv4 = 2'b00;
        @(negedge clk);
        chk("preload_wr_count", wr_count, 16'hFFFE);
        mon_en = 1'b1;
        for (int i = 0; i < 3; i++) exp4.push_back(src(0));
        @(posedge clk); #1 wv4 = 2'b01;
        repeat (3) @(posedge clk);
        #1 wv4 = 2'b00;
        @(negedge clk);
        chk("wrap_wr_count", wr_count, 16'h0001);

        // Reset during a locked requester-1 burst with an output byte held
        exp4.push_back(src(1)); exp4.push_back(src(1));
        @(posedge clk); #1;
        wv4 = 2'b10; rd_ready = 1'b0;
        mem[5] = 8'hF6; wptr = 6;
        repeat (2) @(posedge clk);
        #1 wv4 = 2'b11; rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_write_fifo", 16'(write_fifo), 16'd0);
        chk("mid_rst_wr_ready", 16'(wr_ready), 16'd0);
        chk("mid_rst_rd_valid", 16'(rd_valid), 16'd0);
        chk("mid_rst_wr_count", wr_count, 16'd0);
        exp4.push_back(src(0));
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 wv4 = 2'b00;
        @(negedge clk);
        chk("post_rst_wr_count", wr_count, 16'd1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("exp4_drained", 16'(exp4.size()), 16'd0);
        chk("exp1_drained", 16'(exp1.size()), 16'd0);
        chk("exp_rd_drained", 16'(exp_rd.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
